// File: rtl/axi_addr_demux.sv
// axi_addr_demux: 1-to-N AXI4 address demultiplexer.
// Routes one master onto N_SLAVES windows by base/mask decode, keeps per-direction
// outstanding-burst counters with a locked target, and answers unmapped addresses
// with DECERR from a built-in responder.

package axi_addr_demux_pkg;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [AXI_ID_W-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    arready;
    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
  } s_axi_miso_t;
endpackage

module axi_addr_demux
  import axi_addr_demux_pkg::*;
#(
  parameter int                         N_SLAVES  = 2,
  parameter logic [N_SLAVES-1:0][31:0]  BASE_ADDR = {32'h8000_0000, 32'h1000_0000},
  parameter logic [N_SLAVES-1:0][31:0]  ADDR_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  parameter int                         MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t mst_axi_mosi_i,
  output s_axi_miso_t mst_axi_miso_o,
  output s_axi_mosi_t slv_axi_mosi_o [N_SLAVES],
  input  s_axi_miso_t slv_axi_miso_i [N_SLAVES]
);

  localparam int             TW      = $clog2(N_SLAVES + 1);
  localparam int             CW      = $clog2(MAX_OUTST + 1);
  localparam logic [TW-1:0]  ERR     = TW'(N_SLAVES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTST);
  localparam logic [1:0]     DECERR  = 2'b11;

  typedef enum logic       {R_IDLE, R_DATA}         rd_st_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_st_e;

  // Lowest matching window wins; no match selects the internal error target.
  function automatic logic [TW-1:0] decode(input logic [31:0] addr);
    logic [TW-1:0] t;
    t = ERR;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASK[i]) == BASE_ADDR[i]) t = TW'(i);
    end
    return t;
  endfunction

  // Outstanding counter step: simultaneous inc/dec cancel, never wraps.
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c,
                                             input logic inc, input logic dec);
    logic [CW-1:0] n;
    n = c;
    if (inc && !dec && c != CNT_MAX) n = c + 1'b1;
    else if (dec && !inc && c != '0) n = c - 1'b1;
    return n;
  endfunction

  // Control state
  logic [CW-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, w_owed_q, w_owed_d;
  logic [TW-1:0] rd_tgt_q, rd_tgt_d, wr_tgt_q, wr_tgt_d;
  rd_st_e        rst_q, rst_d;
  wr_st_e        wst_q, wst_d;
  logic          err_ar_seen_q, err_ar_seen_d;
  logic [7:0]    err_rbeat_q, err_rbeat_d;

  // Error-responder data (not reset; only visible while a burst is tracked)
  logic [AXI_ID_W-1:0] err_rid_q, err_bid_q;
  logic [7:0]          err_rlen_q;

  // Decode and channel gating
  logic [TW-1:0] dec_rd, dec_wr;
  logic          rd_fwd, wr_fwd, w_open;
  logic          err_arvalid, err_awvalid;
  logic          err_arready, err_awready, err_wready;
  logic          err_rvalid, err_rlast, err_bvalid;
  logic          ar_rdy, aw_rdy, w_rdy;
  logic          ar_hs, aw_hs, w_last_hs, r_done, b_done;
  logic          err_ar_hs, err_aw_hs, err_r_hs, err_wlast_hs, err_b_hs;

  // Decode, stall decision and error-responder handshake terms
  always_comb begin
    dec_rd      = decode(mst_axi_mosi_i.araddr);
    dec_wr      = decode(mst_axi_mosi_i.awaddr);
    rd_fwd      = (rd_cnt_q == '0 || dec_rd == rd_tgt_q) && rd_cnt_q < CNT_MAX;
    wr_fwd      = (wr_cnt_q == '0 || dec_wr == wr_tgt_q) && wr_cnt_q < CNT_MAX;
    w_open      = w_owed_q != '0;
    err_arvalid = mst_axi_mosi_i.arvalid && rd_fwd && dec_rd == ERR;
    err_awvalid = mst_axi_mosi_i.awvalid && wr_fwd && dec_wr == ERR;
    err_arready = rst_q == R_IDLE && err_ar_seen_q && err_arvalid;
    err_awready = wst_q == W_IDLE && err_awvalid;
    err_wready  = wst_q == W_DATA;
    err_rvalid  = rst_q == R_DATA;
    err_rlast   = err_rbeat_q == err_rlen_q;
    err_bvalid  = wst_q == W_RESP;
  end

  // Master-facing ready muxes, selected by decode (AR/AW) or locked target (W)
  always_comb begin
    ar_rdy = 1'b0;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    if (rd_fwd) begin
      if (dec_rd == ERR) ar_rdy = err_arready;
      for (int i = 0; i < N_SLAVES; i++)
        if (dec_rd == TW'(i)) ar_rdy = slv_axi_miso_i[i].arready;
    end
    if (wr_fwd) begin
      if (dec_wr == ERR) aw_rdy = err_awready;
      for (int i = 0; i < N_SLAVES; i++)
        if (dec_wr == TW'(i)) aw_rdy = slv_axi_miso_i[i].awready;
    end
    if (w_open) begin
      if (wr_tgt_q == ERR) w_rdy = err_wready;
      for (int i = 0; i < N_SLAVES; i++)
        if (wr_tgt_q == TW'(i)) w_rdy = slv_axi_miso_i[i].wready;
    end
  end

  // Master-facing R/B muxes from the locked targets; silent when nothing is outstanding
  always_comb begin
    mst_axi_miso_o         = '0;
    mst_axi_miso_o.arready = ar_rdy;
    mst_axi_miso_o.awready = aw_rdy;
    mst_axi_miso_o.wready  = w_rdy;
    if (rd_cnt_q != '0) begin
      if (rd_tgt_q == ERR) begin
        mst_axi_miso_o.rvalid = err_rvalid;
        mst_axi_miso_o.rid    = err_rid_q;
        mst_axi_miso_o.rdata  = '0;
        mst_axi_miso_o.rresp  = DECERR;
        mst_axi_miso_o.rlast  = err_rlast;
      end
      for (int i = 0; i < N_SLAVES; i++) begin
        if (rd_tgt_q == TW'(i)) begin
          mst_axi_miso_o.rvalid = slv_axi_miso_i[i].rvalid;
          mst_axi_miso_o.rid    = slv_axi_miso_i[i].rid;
          mst_axi_miso_o.rdata  = slv_axi_miso_i[i].rdata;
          mst_axi_miso_o.rresp  = slv_axi_miso_i[i].rresp;
          mst_axi_miso_o.rlast  = slv_axi_miso_i[i].rlast;
        end
      end
    end
    if (wr_cnt_q != '0) begin
      if (wr_tgt_q == ERR) begin
        mst_axi_miso_o.bvalid = err_bvalid;
        mst_axi_miso_o.bid    = err_bid_q;
        mst_axi_miso_o.bresp  = DECERR;
      end
      for (int i = 0; i < N_SLAVES; i++) begin
        if (wr_tgt_q == TW'(i)) begin
          mst_axi_miso_o.bvalid = slv_axi_miso_i[i].bvalid;
          mst_axi_miso_o.bid    = slv_axi_miso_i[i].bid;
          mst_axi_miso_o.bresp  = slv_axi_miso_i[i].bresp;
        end
      end
    end
  end

  // Slave-facing broadcast of payload with valids/readies steered to one port only
  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      slv_axi_mosi_o[i]         = mst_axi_mosi_i;
      slv_axi_mosi_o[i].arvalid = mst_axi_mosi_i.arvalid && rd_fwd && dec_rd == TW'(i);
      slv_axi_mosi_o[i].awvalid = mst_axi_mosi_i.awvalid && wr_fwd && dec_wr == TW'(i);
      slv_axi_mosi_o[i].wvalid  = mst_axi_mosi_i.wvalid && w_open && wr_tgt_q == TW'(i);
      slv_axi_mosi_o[i].rready  = mst_axi_mosi_i.rready && rd_cnt_q != '0 &&
                                  rd_tgt_q == TW'(i);
      slv_axi_mosi_o[i].bready  = mst_axi_mosi_i.bready && wr_cnt_q != '0 &&
                                  wr_tgt_q == TW'(i);
    end
  end

  // Handshake events seen by the master port
  always_comb begin
    ar_hs        = mst_axi_mosi_i.arvalid && ar_rdy;
    aw_hs        = mst_axi_mosi_i.awvalid && aw_rdy;
    w_last_hs    = mst_axi_mosi_i.wvalid && w_rdy && mst_axi_mosi_i.wlast;
    r_done       = mst_axi_miso_o.rvalid && mst_axi_mosi_i.rready && mst_axi_miso_o.rlast;
    b_done       = mst_axi_miso_o.bvalid && mst_axi_mosi_i.bready;
    err_ar_hs    = ar_hs && dec_rd == ERR;
    err_aw_hs    = aw_hs && dec_wr == ERR;
    err_r_hs     = err_rvalid && mst_axi_mosi_i.rready;
    err_wlast_hs = err_wready && w_last_hs;
    err_b_hs     = err_bvalid && mst_axi_mosi_i.bready;
  end

  // Next state for counters, locked targets and both error-responder FSMs
  always_comb begin
    rd_cnt_d      = cnt_step(rd_cnt_q, ar_hs, r_done);
    wr_cnt_d      = cnt_step(wr_cnt_q, aw_hs, b_done);
    w_owed_d      = cnt_step(w_owed_q, aw_hs, w_last_hs);
    rd_tgt_d      = ar_hs ? dec_rd : rd_tgt_q;
    wr_tgt_d      = aw_hs ? dec_wr : wr_tgt_q;
    rst_d         = rst_q;
    wst_d         = wst_q;
    err_rbeat_d   = err_rbeat_q;
    err_ar_seen_d = (rst_q == R_IDLE) && err_arvalid && !err_ar_hs;
    case (rst_q)
      R_IDLE: if (err_ar_hs) begin
        rst_d       = R_DATA;
        err_rbeat_d = '0;
      end
      R_DATA: if (err_r_hs) begin
        if (err_rlast) rst_d = R_IDLE;
        else           err_rbeat_d = err_rbeat_q + 1'b1;
      end
      default: rst_d = R_IDLE;
    endcase
    case (wst_q)
      W_IDLE:  if (err_aw_hs)    wst_d = W_DATA;
      W_DATA:  if (err_wlast_hs) wst_d = W_RESP;
      W_RESP:  if (err_b_hs)     wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      w_owed_q      <= '0;
      rd_tgt_q      <= '0;
      wr_tgt_q      <= '0;
      rst_q         <= R_IDLE;
      wst_q         <= W_IDLE;
      err_ar_seen_q <= 1'b0;
      err_rbeat_q   <= '0;
    end else begin
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      w_owed_q      <= w_owed_d;
      rd_tgt_q      <= rd_tgt_d;
      wr_tgt_q      <= wr_tgt_d;
      rst_q         <= rst_d;
      wst_q         <= wst_d;
      err_ar_seen_q <= err_ar_seen_d;
      err_rbeat_q   <= err_rbeat_d;
    end
  end

  // Latch ID/length of the burst taken by the error responder
  always_ff @(posedge clk) begin
    if (err_ar_hs) begin
      err_rid_q  <= mst_axi_mosi_i.arid;
      err_rlen_q <= mst_axi_mosi_i.arlen;
    end
    if (err_aw_hs) err_bid_q <= mst_axi_mosi_i.awid;
  end

endmodule

// File: tb/tb_axi_addr_demux.sv
// Directed bench for axi_addr_demux: two mapped slaves plus the DECERR responder.
module tb_axi_addr_demux;
  import axi_addr_demux_pkg::*;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t mst;
  s_axi_miso_t mst_o;
  s_axi_mosi_t slv_o [N];
  s_axi_miso_t slv_i [N];

  int n_chk  = 0;
  int n_fail = 0;

  axi_addr_demux #(.N_SLAVES(N), .MAX_OUTST(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mst_axi_mosi_i (mst),
    .mst_axi_miso_o (mst_o),
    .slv_axi_mosi_o (slv_o),
    .slv_axi_miso_i (slv_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    mst = '0;
    for (int i = 0; i < N; i++) slv_i[i] = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_arready", mst_o.arready, 0);
    chk("rst_awready", mst_o.awready, 0);
    chk("rst_wready",  mst_o.wready, 0);
    chk("rst_rvalid",  mst_o.rvalid, 0);
    chk("rst_bvalid",  mst_o.bvalid, 0);
    chk("rst_rdata",   mst_o.rdata, 0);
    chk("rst_s0_arvalid", slv_o[0].arvalid, 0);
    chk("rst_rd_cnt",  dut.rd_cnt_q, 0);
    chk("rst_wr_cnt",  dut.wr_cnt_q, 0);

    // Single reads: slave 1 then slave 0, second stalls until first rlast
    slv_i[0].arready = 1'b1;
    slv_i[1].arready = 1'b1;
    tick();
    mst.arvalid = 1'b1; mst.araddr = 32'h8000_0010; mst.arid = 4'd1; mst.arlen = 8'd0;
    #1;
    chk("t1_s1_arvalid", slv_o[1].arvalid, 1);
    chk("t1_s0_arvalid", slv_o[0].arvalid, 0);
    chk("t1_arready",    mst_o.arready, 1);
    tick();
    mst.araddr = 32'h1000_0004; mst.arid = 4'd2;
    slv_i[1].rvalid = 1'b1; slv_i[1].rdata = 32'hAAAA_1111; slv_i[1].rlast = 1'b1;
    slv_i[1].rid = 4'd1;
    mst.rready = 1'b1;
    #1;
    chk("t1_stall_arready", mst_o.arready, 0);
    chk("t1_stall_s0_arvalid", slv_o[0].arvalid, 0);
    chk("t1_rvalid", mst_o.rvalid, 1);
    chk("t1_rdata1", mst_o.rdata, 32'hAAAA_1111);
    chk("t1_s1_rready", slv_o[1].rready, 1);
    chk("t1_s0_rready", slv_o[0].rready, 0);
    tick();
    slv_i[1].rvalid = 1'b0;
    #1;
    chk("t1_switch_arready", mst_o.arready, 1);
    chk("t1_switch_s0_arvalid", slv_o[0].arvalid, 1);
    tick();
    mst.arvalid = 1'b0;
    slv_i[0].rvalid = 1'b1; slv_i[0].rdata = 32'hBBBB_0000; slv_i[0].rlast = 1'b1;
    #1;
    chk("t1_rdata0", mst_o.rdata, 32'hBBBB_0000);
    tick();
    slv_i[0].rvalid = 1'b0;
    mst.rready = 1'b0;

    // Pipelining: four ARs to slave 1, fifth stalls at saturation
    for (int k = 0; k < 4; k++) begin
      tick();
      mst.arvalid = 1'b1; mst.araddr = 32'h8000_0100; mst.arid = 4'(k);
      #1;
      chk("t2_accept", mst_o.arready, 1);
    end
    tick();
    #1;
    chk("t2_rd_cnt4", dut.rd_cnt_q, 4);
    chk("t2_sat_arready", mst_o.arready, 0);
    for (int k = 0; k < 10; k++) tick();
    #1;
    chk("t2_sat_hold", mst_o.arready, 0);
    slv_i[1].rvalid = 1'b1; slv_i[1].rlast = 1'b1; mst.rready = 1'b1;
    tick();
    slv_i[1].rvalid = 1'b0;
    #1;
    chk("t2_fifth_accept", mst_o.arready, 1);
    tick();
    mst.arvalid = 1'b0;
    slv_i[1].rvalid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    slv_i[1].rvalid = 1'b0;
    #1;
    chk("t2_rd_cnt0", dut.rd_cnt_q, 0);
    chk("t2_rvalid0", mst_o.rvalid, 0);

    // Unmapped read: DECERR burst of 4 beats
    tick();
    mst.arvalid = 1'b1; mst.araddr = 32'h4000_0000; mst.arlen = 8'd3; mst.arid = 4'd5;
    #1;
    chk("t3_arready_c0", mst_o.arready, 0);
    chk("t3_s0_arvalid", slv_o[0].arvalid, 0);
    chk("t3_s1_arvalid", slv_o[1].arvalid, 0);
    tick();
    #1;
    chk("t3_arready_c1", mst_o.arready, 1);
    tick();
    mst.arvalid = 1'b0; mst.rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_rvalid", mst_o.rvalid, 1);
      chk("t3_rlast", mst_o.rlast, (k == 3) ? 1 : 0);
      chk("t3_rid", mst_o.rid, 5);
      chk("t3_rresp", mst_o.rresp, 2'b11);
      chk("t3_rdata", mst_o.rdata, 0);
      tick();
    end
    #1;
    chk("t3_done_rvalid", mst_o.rvalid, 0);
    chk("t3_rd_cnt0", dut.rd_cnt_q, 0);
    mst.rready = 1'b0;

    // Unmapped write: AW + 2 W beats sunk, DECERR B
    tick();
    mst.awvalid = 1'b1; mst.awaddr = 32'h4000_0000; mst.awid = 4'd7; mst.awlen = 8'd1;
    #1;
    chk("t4_awready", mst_o.awready, 1);
    chk("t4_s0_awvalid", slv_o[0].awvalid, 0);
    chk("t4_s1_awvalid", slv_o[1].awvalid, 0);
    tick();
    mst.awvalid = 1'b0; mst.wvalid = 1'b1; mst.wlast = 1'b0; mst.wdata = 32'h1234_5678;
    #1;
    chk("t4_wready_b0", mst_o.wready, 1);
    chk("t4_s0_wvalid", slv_o[0].wvalid, 0);
    chk("t4_s1_wvalid", slv_o[1].wvalid, 0);
    tick();
    mst.wlast = 1'b1;
    #1;
    chk("t4_wready_b1", mst_o.wready, 1);
    tick();
    mst.wvalid = 1'b0; mst.wlast = 1'b0; mst.bready = 1'b1;
    #1;
    chk("t4_bvalid", mst_o.bvalid, 1);
    chk("t4_bresp", mst_o.bresp, 2'b11);
    chk("t4_bid", mst_o.bid, 7);
    tick();
    #1;
    chk("t4_bvalid_done", mst_o.bvalid, 0);
    mst.bready = 1'b0;

    // W before AW to slave 0
    slv_i[0].awready = 1'b1; slv_i[0].wready = 1'b1;
    slv_i[1].wready = 1'b1;
    tick();
    mst.wvalid = 1'b1; mst.wlast = 1'b1; mst.wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_early_wready", mst_o.wready, 0);
      chk("t5_early_s0_wvalid", slv_o[0].wvalid, 0);
      tick();
    end
    mst.awvalid = 1'b1; mst.awaddr = 32'h1000_0020; mst.awid = 4'd3; mst.awlen = 8'd0;
    #1;
    chk("t5_awready", mst_o.awready, 1);
    chk("t5_s0_awvalid", slv_o[0].awvalid, 1);
    chk("t5_s1_awvalid", slv_o[1].awvalid, 0);
    chk("t5_wready_at_aw", mst_o.wready, 0);
    tick();
    mst.awvalid = 1'b0;
    #1;
    chk("t5_wready", mst_o.wready, 1);
    chk("t5_s0_wvalid", slv_o[0].wvalid, 1);
    chk("t5_s0_wdata", slv_o[0].wdata, 32'hDEAD_BEEF);
    chk("t5_s1_wvalid", slv_o[1].wvalid, 0);
    tick();
    mst.wvalid = 1'b0; mst.wlast = 1'b0; mst.bready = 1'b1;
    slv_i[0].bvalid = 1'b1; slv_i[0].bid = 4'd3; slv_i[0].bresp = 2'b00;
    slv_i[1].bvalid = 1'b1; slv_i[1].bid = 4'd9; slv_i[1].bresp = 2'b10;
    #1;
    chk("t5_bvalid", mst_o.bvalid, 1);
    chk("t5_bid", mst_o.bid, 3);
    chk("t5_bresp", mst_o.bresp, 2'b00);
    chk("t5_s1_bready", slv_o[1].bready, 0);
    tick();
    slv_i[0].bvalid = 1'b0; slv_i[1].bvalid = 1'b0; mst.bready = 1'b0;
    #1;
    chk("t5_wr_cnt0", dut.wr_cnt_q, 0);

    // Reset during beat 2 of a 4-beat read from slave 0
    tick();
    mst.arvalid = 1'b1; mst.araddr = 32'h1000_0040; mst.arlen = 8'd3; mst.arid = 4'd4;
    #1;
    chk("t6_arready", mst_o.arready, 1);
    tick();
    mst.arvalid = 1'b0; mst.rready = 1'b1;
    slv_i[0].rvalid = 1'b1; slv_i[0].rlast = 1'b0; slv_i[0].rdata = 32'h0000_0001;
    #1;
    chk("t6_beat1", mst_o.rvalid, 1);
    tick();
    rst = 1'b1; slv_i[0].rdata = 32'h0000_0002;
    tick();
    rst = 1'b0;
    mst.arvalid = 1'b1; mst.araddr = 32'h8000_0000; mst.arid = 4'd6; mst.arlen = 8'd0;
    #1;
    chk("t6_rd_cnt", dut.rd_cnt_q, 0);
    chk("t6_wr_cnt", dut.wr_cnt_q, 0);
    chk("t6_w_owed", dut.w_owed_q, 0);
    chk("t6_stale_rvalid", mst_o.rvalid, 0);
    chk("t6_stale_s0_rready", slv_o[0].rready, 0);
    chk("t6_bvalid", mst_o.bvalid, 0);
    chk("t6_new_arready", mst_o.arready, 1);
    chk("t6_new_s1_arvalid", slv_o[1].arvalid, 1);
    tick();
    mst.arvalid = 1'b0;
    slv_i[0].rvalid = 1'b0;
    slv_i[1].rvalid = 1'b1; slv_i[1].rlast = 1'b1; slv_i[1].rdata = 32'h0000_0066;
    #1;
    chk("t6_new_rdata", mst_o.rdata, 32'h0000_0066);
    tick();
    slv_i[1].rvalid = 1'b0; mst.rready = 1'b0;
    #1;
    chk("t6_final_rd_cnt", dut.rd_cnt_q, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
